// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output back end.
package fir_pkg;

    localparam int unsigned DATA_IN_W    = 33;
    localparam int unsigned DATA_OUT_W   = 16;
    localparam int unsigned FRAC_SHIFT_D = 15;
    localparam int unsigned DECIM_D      = 4;
    localparam int unsigned PRIME_D      = 2;
    localparam int unsigned FIFO_DEPTH_D = 4;

    localparam int unsigned SUM_W = DATA_IN_W + 1;

    // Half-LSB of the output grid, added before the arithmetic shift
    localparam logic signed [SUM_W-1:0] ROUND_CONST = SUM_W'(1) << (FRAC_SHIFT_D - 1);

    localparam logic signed [DATA_OUT_W-1:0] OUT_MAX = {1'b0, {(DATA_OUT_W - 1){1'b1}}};
    localparam logic signed [DATA_OUT_W-1:0] OUT_MIN = {1'b1, {(DATA_OUT_W - 1){1'b0}}};

    typedef enum logic [0:0] {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO buffering decimated samples; head is always presented on o_rdata.
module fir_out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [WIDTH-1:0]            i_wdata,
    output logic [WIDTH-1:0]            o_rdata,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int unsigned PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_en;
    logic             rd_en;

    // Accept a write when full only if a read frees the slot in the same cycle
    always_comb begin
        rd_en     = i_pop && !o_empty;
        wr_en     = i_push && (!o_full || rd_en);
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= i_wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_nxt;
            o_empty <= (count_nxt == '0);
            o_full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    assign o_rdata = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/fir_output_decimator.sv
// Back end of the FIR filter: discards pipeline-fill samples, decimates,
// rounds/saturates to the output width and streams through a small FIFO.
module fir_output_decimator
    import fir_pkg::*;
#(
    parameter int unsigned DATA_IN_WIDTH  = DATA_IN_W,
    parameter int unsigned DATA_OUT_WIDTH = DATA_OUT_W,
    parameter int unsigned FRAC_SHIFT     = FRAC_SHIFT_D,
    parameter int unsigned DECIM          = DECIM_D,
    parameter int unsigned PRIME          = PRIME_D,
    parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_D
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_fir_en,
    input  logic signed [DATA_IN_WIDTH-1:0]    i_fir_data,
    input  logic                               i_ready,
    output logic signed [DATA_OUT_WIDTH-1:0]   o_data,
    output logic                               o_valid,
    output logic                               o_sat,
    output logic                               o_overflow
);

    localparam int unsigned ACC_W   = DATA_IN_WIDTH + 1;
    localparam int unsigned CNT_MAX = (PRIME > DECIM) ? PRIME : DECIM;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'((PRIME == 0) ? 0 : PRIME - 1);
    localparam logic [CNT_W-1:0] DECIM_LAST = CNT_W'((DECIM == 0) ? 0 : DECIM - 1);

    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'((1 << (DATA_OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO  = ~SAT_HI;

    state_t                           state;
    state_t                           state_nxt;
    logic [CNT_W-1:0]                 cnt;
    logic [CNT_W-1:0]                 cnt_nxt;
    logic                             en_d;
    logic                             keep_c;

    logic signed [ACC_W-1:0]          sum_c;
    logic signed [ACC_W-1:0]          shift_c;
    logic signed [DATA_OUT_WIDTH-1:0] sample_c;
    logic                             sat_c;

    logic                             fifo_full;
    logic                             fifo_empty;
    logic [FCNT_W-1:0]                fifo_count;
    logic                             pop_c;
    logic                             push_ok_c;
    logic                             drop_c;

    // The filter output register updates on the enable edge, so en_d marks a fresh sample
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            en_d  <= 1'b0;
            state <= S_PRIME;
            cnt   <= '0;
        end else begin
            en_d  <= i_fir_en;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts discarded fill samples in S_PRIME and is the decimation phase in S_RUN
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        keep_c    = 1'b0;
        case (state)
            S_PRIME: begin
                if (PRIME == 0) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else if (en_d) begin
                    if (cnt == PRIME_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (en_d) begin
                    keep_c  = (cnt == '0);
                    cnt_nxt = (cnt == DECIM_LAST) ? '0 : cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_PRIME;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Round half toward +inf, then clamp to the signed output range
    always_comb begin
        sum_c    = $signed({i_fir_data[DATA_IN_WIDTH-1], i_fir_data}) + ROUND_C;
        shift_c  = sum_c >>> FRAC_SHIFT;
        sample_c = shift_c[DATA_OUT_WIDTH-1:0];
        sat_c    = 1'b0;
        if (shift_c > SAT_HI) begin
            sample_c = SAT_HI[DATA_OUT_WIDTH-1:0];
            sat_c    = 1'b1;
        end else if (shift_c < SAT_LO) begin
            sample_c = SAT_LO[DATA_OUT_WIDTH-1:0];
            sat_c    = 1'b1;
        end
    end

    always_comb begin
        pop_c     = o_valid && i_ready;
        push_ok_c = keep_c && (!fifo_full || pop_c);
        drop_c    = keep_c && fifo_full && !pop_c;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sat      <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_sat      <= push_ok_c && sat_c;
            o_overflow <= o_overflow || drop_c;
            assert (fifo_count <= FCNT_W'(FIFO_DEPTH));
        end
    end

    fir_out_fifo #(
        .WIDTH (DATA_OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_ok_c),
        .i_pop   (pop_c),
        .i_wdata (sample_c),
        .o_rdata (o_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign o_valid = ~fifo_empty;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed self-checking bench for fir_output_decimator at default parameters.
module tb_fir_output_decimator;
    import fir_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               fir_en;
    logic signed [32:0] fir_data;
    logic               ready;
    logic signed [15:0] o_data;
    logic               o_valid;
    logic               o_sat;
    logic               o_overflow;

    int checks;
    int failures;

    fir_output_decimator dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_fir_en   (fir_en),
        .i_fir_data (fir_data),
        .i_ready    (ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_sat      (o_sat),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enable for one cycle with new filter data; returns in the fresh-sample cycle
    task automatic pulse(input longint v);
        fir_en   = 1'b1;
        fir_data = 33'(v);
        tick();
        fir_en   = 1'b0;
    endtask

    task automatic filler(input int n);
        repeat (n) begin
            pulse(0);
            tick();
        end
    endtask

    // Reset and consume the two fill samples so the phase counter sits at 0
    task automatic start();
        rst_n  = 1'b0;
        fir_en = 1'b0;
        ready  = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        pulse(0);
        tick();
        pulse(0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fir_en   = 1'b1;
            fir_data = 33'(longint'(32768) * (i + 2));
            tick();
        end
        fir_en = 1'b0;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b exp 0", o_valid); end
        checks++; if (o_data !== 16'sd0) begin failures++; $display("FAIL rst_data got %0d exp 0", o_data); end
        checks++; if (o_sat !== 1'b0) begin failures++; $display("FAIL rst_sat got %b exp 0", o_sat); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got %b exp 0", o_overflow); end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pulse(longint'(32768) * 5);
            tick();
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_prime%0d got %b exp 0", i, o_valid); end
            tick();
        end
        pulse(longint'(32768) * 6);
        tick();
        checks++; if (o_valid !== 1'b1 || o_data !== 16'sd6) begin
            failures++; $display("FAIL rst_first_kept got v=%b d=%0d exp v=1 d=6", o_valid, o_data);
        end
    endtask

    task automatic test_rounding();
        longint             rin [5] = '{32768, 16384, 16383, -16384, -16385};
        logic signed [15:0] rexp[5] = '{16'sd1, 16'sd1, 16'sd0, 16'sd0, -16'sd1};
        start();
        for (int i = 0; i < 5; i++) begin
            pulse(rin[i]);
            tick();
            checks++; if (o_valid !== 1'b1 || o_data !== rexp[i]) begin
                failures++; $display("FAIL round%0d got v=%b d=%0d exp v=1 d=%0d", i, o_valid, o_data, rexp[i]);
            end
            checks++; if (o_sat !== 1'b0) begin failures++; $display("FAIL round_sat%0d got %b exp 0", i, o_sat); end
            filler(3);
            checks++; if (o_sat !== 1'b0 || o_valid !== 1'b0) begin
                failures++; $display("FAIL round_idle%0d got s=%b v=%b exp s=0 v=0", i, o_sat, o_valid);
            end
        end
    endtask

    task automatic test_saturation();
        longint             sin [2] = '{64'sd2147483647, -64'sd4294967296};
        logic signed [15:0] sexp[2] = '{16'sd32767, -16'sd32768};
        start();
        for (int i = 0; i < 2; i++) begin
            pulse(sin[i]);
            checks++; if (o_sat !== 1'b0) begin failures++; $display("FAIL sat_pre%0d got %b exp 0", i, o_sat); end
            tick();
            checks++; if (o_valid !== 1'b1 || o_data !== sexp[i]) begin
                failures++; $display("FAIL sat%0d got v=%b d=%0d exp v=1 d=%0d", i, o_valid, o_data, sexp[i]);
            end
            checks++; if (o_sat !== 1'b1) begin failures++; $display("FAIL sat_pulse%0d got %b exp 1", i, o_sat); end
            tick();
            checks++; if (o_sat !== 1'b0) begin failures++; $display("FAIL sat_once%0d got %b exp 0", i, o_sat); end
            tick();
            filler(3);
        end
    endtask

    task automatic test_decimation();
        int nout = 0;
        rst_n  = 1'b0;
        fir_en = 1'b0;
        ready  = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic kept;
            kept = (k == 3) || (k == 7) || (k == 11);
            fir_en   = 1'b1;
            fir_data = 33'(longint'(32768) * k);
            tick();
            fir_en = 1'b0;
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL dec_early k=%0d got %b exp 0", k, o_valid); end
            tick();
            if (kept) begin
                nout++;
                checks++; if (o_valid !== 1'b1 || o_data !== 16'(k)) begin
                    failures++; $display("FAIL dec_out k=%0d got v=%b d=%0d exp v=1 d=%0d", k, o_valid, o_data, k);
                end
            end else begin
                checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL dec_skip k=%0d got %b exp 0", k, o_valid); end
            end
            tick();
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL dec_pop k=%0d got %b exp 0", k, o_valid); end
        end
        checks++; if (nout != 3) begin failures++; $display("FAIL dec_count got %0d exp 3", nout); end
    endtask

    task automatic test_overflow();
        start();
        ready = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            pulse(longint'(32768) * j);
            tick();
            checks++; if (o_overflow !== (j >= 5)) begin
                failures++; $display("FAIL ovf_flag j=%0d got %b exp %b", j, o_overflow, (j >= 5));
            end
            checks++; if (o_valid !== 1'b1 || o_data !== 16'sd1) begin
                failures++; $display("FAIL ovf_head j=%0d got v=%b d=%0d exp v=1 d=1", j, o_valid, o_data);
            end
            filler(3);
        end
        ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            checks++; if (o_valid !== 1'b1 || o_data !== 16'(j)) begin
                failures++; $display("FAIL ovf_drain%0d got v=%b d=%0d exp v=1 d=%0d", j, o_valid, o_data, j);
            end
            tick();
        end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got %b exp 0", o_valid); end
        checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b exp 1", o_overflow); end
    endtask

    task automatic test_full_push_pop();
        start();
        ready = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            pulse(longint'(32768) * j);
            tick();
            filler(3);
        end
        pulse(longint'(32768) * 5);
        ready = 1'b1;
        tick();
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got %b exp 0", o_overflow); end
        for (int j = 2; j <= 5; j++) begin
            checks++; if (o_valid !== 1'b1 || o_data !== 16'(j)) begin
                failures++; $display("FAIL fpp_order%0d got v=%b d=%0d exp v=1 d=%0d", j, o_valid, o_data, j);
            end
            tick();
        end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL fpp_empty got %b exp 0", o_valid); end
    endtask

    task automatic test_mid_reset();
        start();
        ready = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            pulse(longint'(32768) * j);
            tick();
            filler(3);
        end
        checks++; if (o_valid !== 1'b1 || o_data !== 16'sd1) begin
            failures++; $display("FAIL mid_pre got v=%b d=%0d exp v=1 d=1", o_valid, o_data);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (o_valid !== 1'b0 || o_data !== 16'sd0) begin
            failures++; $display("FAIL mid_flush got v=%b d=%0d exp v=0 d=0", o_valid, o_data);
        end
        checks++; if (dut.state !== S_PRIME) begin failures++; $display("FAIL mid_state got %0d exp %0d", dut.state, S_PRIME); end
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pulse(longint'(32768) * 9);
            tick();
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_prime%0d got %b exp 0", i, o_valid); end
        end
        pulse(longint'(32768) * 7);
        tick();
        checks++; if (o_valid !== 1'b1 || o_data !== 16'sd7) begin
            failures++; $display("FAIL mid_kept got v=%b d=%0d exp v=1 d=7", o_valid, o_data);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        fir_en   = 1'b0;
        fir_data = '0;
        ready    = 1'b1;
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_output_decimator.md
# fir_output_decimator

Back-end companion to the 50th-order FIR filter. It consumes the filter's 33-bit full-precision output on the same sample enable, discards the pipeline-fill samples after reset, and decimates by DECIM. Each kept sample is rounded and saturated to 16 bits, buffered in a small FIFO, and delivered over a valid/ready stream to the downstream consumer.

## Interface
- DATA_IN_WIDTH, 33: width of the signed filter output consumed.
- DATA_OUT_WIDTH, 16: width of the signed output sample.
- FRAC_SHIFT, 15: right shift applied before saturation; taps are Q1.15.
- DECIM, 4: decimation factor; 1 disables decimation.
- PRIME, 2: number of fresh filter outputs discarded after reset.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two.

Ports:
- i_clk, in, 1: single clock; every register is clocked on its rising edge.
- i_rst_n, in, 1: synchronous, active-low reset, sampled on the i_clk rising edge.
- i_fir_en, in, 1: the same enable that drives the FIR filter; one pulse per input sample.
- i_fir_data, in, DATA_IN_WIDTH, signed: filter output register.
- i_ready, in, 1: downstream ready.
- o_data, out, DATA_OUT_WIDTH, signed: FIFO head. Reset value 0.
- o_valid, out, 1: FIFO non-empty. Reset value 0.
- o_sat, out, 1: one-cycle pulse when a pushed sample was saturated. Reset value 0.
- o_overflow, out, 1: sticky; set when a kept sample is dropped because the FIFO is full. Cleared only by reset. Reset value 0.

## Operation
- Fresh-sample detect: en_d is i_fir_en registered. The filter updates its output on the enable edge, so i_fir_data is a new sample in every cycle where en_d=1.
- State machine, two states:
  - S_PRIME (reset state): counts fresh samples and discards them. After PRIME of them it moves to S_RUN. With PRIME=0 it goes directly to S_RUN on the first cycle after reset.
  - S_RUN: a phase counter runs 0..DECIM-1, advances on each fresh sample, and wraps to 0. Only a sample arriving at phase 0 is kept.
  - The first fresh sample seen in S_RUN is at phase 0.
- Arithmetic on a kept sample:
  - t = i_fir_data + 2^(FRAC_SHIFT-1), computed at DATA_IN_WIDTH+1 bits.
  - Arithmetic shift right by FRAC_SHIFT (round half up, toward +inf).
  - Clamp to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1].
  - o_sat pulses in the cycle after the push when the clamp was active.
- FIFO:
  - Push a kept sample.
  - Pop when o_valid && i_ready.
  - Push while full with no pop: drop the sample and set o_overflow. A sample dropped this way does not pulse o_sat.
  - Push and pop in the same cycle while full: both proceed and the count is unchanged.
  - Push and pop in the same cycle while empty: impossible, because o_valid is 0.
- Stream rules:
  - o_data and o_valid stay stable while o_valid && !i_ready.
  - Samples leave in arrival order.
- Idle behaviour: with i_fir_en held low, no state changes except FIFO pops.
- Reset asserted mid-operation: on the next edge the FIFO is flushed, the state returns to S_PRIME, the counters are zeroed, and all outputs take their reset values. Samples held in the FIFO are lost.

## Timing
- Example path: i_fir_en high in cycle t → en_d high in t+1 → push at the end of t+1 → o_valid and o_data visible in t+2 if the FIFO was empty.
- Latency is 2 cycles from the enable to output valid.
- Pop takes effect at the clock edge; the next head appears in the following cycle.
- Full throughput is one kept sample per cycle (i_fir_en continuously high with DECIM=1) while i_ready=1.
- Reset takes effect one edge after i_rst_n is sampled low. Outputs are at reset values from the following cycle.

## Structure
- Shared package fir_pkg holds:
  - the width constants;
  - the rounding constant 2^(FRAC_SHIFT-1);
  - the saturation limits OUT_MAX and OUT_MIN;
  - the state enum {S_PRIME, S_RUN}.
- One sub-module, fir_out_fifo: a synchronous FIFO with the same i_clk and i_rst_n, providing push, pop, full, empty and count.
- The top level contains the enable delay, the state machine, the phase counter and the round/saturate datapath.

## Test plan
All scenarios use default parameters.
- Reset: hold i_rst_n=0 for 3 cycles with traffic present → o_valid=0, o_data=0, o_sat=0, o_overflow=0; the first 2 fresh samples after release are not output.
- Rounding:
  - Kept inputs 32768, 16384, 16383, -16384 and -16385 → outputs 1, 1, 0, 0 and -1.
  - o_sat stays 0 throughout.
- Saturation: kept inputs 2^31-1 and -2^32 → outputs 32767 and -32768, with o_sat pulsing once for each.
- Decimation and latency:
  - Stimulus: 12 enables, one every 3 cycles, with i_fir_data = 32768 × k for fresh sample k = 1..12, and i_ready=1.
  - Response: outputs 3, 7 and 11 only.
  - Each output has o_valid high exactly 2 cycles after its enable.
- Backpressure and overflow:
  - Stimulus: i_ready=0 while 6 samples are kept.
  - o_overflow sets on the 5th kept sample and stays set.
  - After i_ready=1, the first 4 samples drain in order and o_valid then falls.
  - Full with push and pop in the same cycle → no drop, order preserved.
- Reset mid-stream: assert i_rst_n=0 for 1 cycle with 3 entries held in the FIFO → FIFO empty, state S_PRIME, and the next 2 fresh samples are discarded.
